// File: rtl/mips_front_end.sv
// MIPS32 fetch/decode/execute front end: PC, register file, D/X register and ALU/branch unit.
// Memory, writeback and hazard detection live outside and feed back bypass/writeback inputs.
module mips_front_end #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter logic [31:0] MEM_DEPTH = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic        i_mem_enable,
  output logic        i_rw,
  output logic [1:0]  i_access_size,
  input  logic [31:0] i_insn,
  input  logic        stall,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] mx_data,
  input  logic [31:0] wx_data,
  input  logic        do_mx_a,
  input  logic        do_mx_b,
  input  logic        do_wx_a,
  input  logic        do_wx_b,
  output logic [31:0] ir_dx,
  output logic [31:0] pc_dx,
  output logic [4:0]  rd_dx,
  output logic        rwe_dx,
  output logic        dmwe_dx,
  output logic        rwd_dx,
  output logic        rdst_dx,
  output logic [31:0] alu_out,
  output logic [31:0] rb_out,
  output logic        do_branch,
  output logic [31:0] pc_effective
);
  localparam logic [5:0] NOP_OP = 6'b100001;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
    OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
    FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
    FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  typedef struct packed {
    logic [31:0] ir, pc, ra, rb;
    logic [4:0]  rd;
    logic [5:0]  aluop;
    logic        aluinb, rdst, dmwe, rwd, rwe, br, jp;
  } dx_t;

  logic [31:0] pc, gpr [32];
  dx_t dx, dec;

  assign i_address     = pc;
  assign i_mem_enable  = 1'b1;
  assign i_rw          = 1'b1;
  assign i_access_size = 2'b00;

  always_ff @(posedge clock or posedge reset)
    if (reset)          pc <= BASE_ADDR;
    else if (do_branch) pc <= pc_effective;
    else if (!stall)    pc <= pc + 32'd4;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      gpr[29] <= BASE_ADDR + MEM_DEPTH;
      gpr[31] <= 32'hDEADBEEF;
    end else if (wb_we && wb_rd != 5'd0) gpr[wb_rd] <= wb_data;

  // Decode; register reads see this cycle's writeback (write-through)
  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  assign op = i_insn[31:26];
  assign fn = i_insn[5:0];
  assign rs = i_insn[25:21];
  assign rt = i_insn[20:16];

  always_comb begin
    dec       = '0;
    dec.ir    = i_insn;
    dec.pc    = pc;
    dec.aluop = (op == 6'h00) ? fn : op;
    dec.ra    = (rs == 5'd0) ? '0 : (wb_we && wb_rd == rs) ? wb_data : gpr[rs];
    dec.rb    = (rt == 5'd0) ? '0 : (wb_we && wb_rd == rt) ? wb_data : gpr[rt];
    case (op)
      6'h00: case (fn)
        FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
        FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin dec.rdst = 1'b1; dec.rwe = 1'b1; end
        FN_JR:   begin dec.rdst = 1'b1; dec.jp = 1'b1; end
        default: ;
      endcase
      OP_J:    dec.jp = 1'b1;
      OP_JAL:  begin dec.jp = 1'b1; dec.rwe = 1'b1; end
      OP_BEQ, OP_BNE: dec.br = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        begin dec.aluinb = 1'b1; dec.rwe = 1'b1; end
      OP_LW:   begin dec.aluinb = 1'b1; dec.rwe = 1'b1; dec.rwd = 1'b1; end
      OP_SW:   begin dec.aluinb = 1'b1; dec.dmwe = 1'b1; end
      default: ;
    endcase
    dec.rd = dec.rdst ? i_insn[15:11] : (op == OP_JAL) ? 5'd31 : rt;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset || stall) begin
      dx       <= '0;
      dx.aluop <= NOP_OP;
    end else dx <= dec;

  assign ir_dx   = dx.ir;
  assign pc_dx   = dx.pc;
  assign rd_dx   = dx.rd;
  assign rwe_dx  = dx.rwe;
  assign dmwe_dx = dx.dmwe;
  assign rwd_dx  = dx.rwd;
  assign rdst_dx = dx.rdst;

  // Execute
  logic [5:0]  opx;
  logic [31:0] a, b, simm, pc4;
  assign opx    = dx.ir[31:26];
  assign a      = do_mx_a ? mx_data : do_wx_a ? wx_data : dx.ra;
  assign rb_out = do_mx_b ? mx_data : do_wx_b ? wx_data : dx.rb;
  assign simm   = {{16{dx.ir[15]}}, dx.ir[15:0]};
  assign b      = !dx.aluinb ? rb_out :
                  (opx == OP_ANDI || opx == OP_ORI || opx == OP_XORI) ? {16'h0, dx.ir[15:0]} : simm;
  assign pc4    = dx.pc + 32'd4;

  always_comb begin
    alu_out = '0;
    if (dx.rdst)
      case (dx.aluop)
        FN_ADD, FN_ADDU: alu_out = a + b;
        FN_SUB, FN_SUBU: alu_out = a - b;
        FN_AND:  alu_out = a & b;
        FN_OR:   alu_out = a | b;
        FN_XOR:  alu_out = a ^ b;
        FN_NOR:  alu_out = ~(a | b);
        FN_SLT:  alu_out = {31'h0, $signed(a) < $signed(b)};
        FN_SLTU: alu_out = {31'h0, a < b};
        FN_SLL:  alu_out = b << dx.ir[10:6];
        FN_SRL:  alu_out = b >> dx.ir[10:6];
        FN_SRA:  alu_out = $signed(b) >>> dx.ir[10:6];
        default: ;
      endcase
    else
      case (opx)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_out = a + b;
        OP_SLTI:  alu_out = {31'h0, $signed(a) < $signed(b)};
        OP_SLTIU: alu_out = {31'h0, a < b};
        OP_ANDI:  alu_out = a & b;
        OP_ORI:   alu_out = a | b;
        OP_XORI:  alu_out = a ^ b;
        OP_LUI:   alu_out = {dx.ir[15:0], 16'h0};
        OP_JAL:   alu_out = dx.pc + 32'd8;
        default: ;
      endcase
  end

  // Bubbles carry br = jp = 0, so they never redirect
  assign do_branch    = dx.jp | (dx.br & ((opx == OP_BEQ) == (a == rb_out)));
  assign pc_effective = dx.br   ? pc4 + {simm[29:0], 2'b00} :
                        dx.rdst ? a : {pc4[31:28], dx.ir[25:0], 2'b00};
endmodule

// File: tb/tb_mips_front_end.sv
// Directed bench for mips_front_end: small program table per scenario, hand-computed expectations.
module tb_mips_front_end;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] i_address, i_insn;
  logic        i_mem_enable, i_rw;
  logic [1:0]  i_access_size;
  logic        stall = 0, wb_we = 0, do_mx_a = 0, do_mx_b = 0, do_wx_a = 0, do_wx_b = 0;
  logic [4:0]  wb_rd = 0, rd_dx;
  logic [31:0] wb_data = 0, mx_data = 0, wx_data = 0;
  logic [31:0] ir_dx, pc_dx, alu_out, rb_out, pc_effective;
  logic        rwe_dx, dmwe_dx, rwd_dx, rdst_dx, do_branch;

  mips_front_end dut (
    .clock(clock), .reset(reset), .i_address(i_address), .i_mem_enable(i_mem_enable),
    .i_rw(i_rw), .i_access_size(i_access_size), .i_insn(i_insn), .stall(stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mx_data(mx_data), .wx_data(wx_data),
    .do_mx_a(do_mx_a), .do_mx_b(do_mx_b), .do_wx_a(do_wx_a), .do_wx_b(do_wx_b),
    .ir_dx(ir_dx), .pc_dx(pc_dx), .rd_dx(rd_dx), .rwe_dx(rwe_dx), .dmwe_dx(dmwe_dx),
    .rwd_dx(rwd_dx), .rdst_dx(rdst_dx), .alu_out(alu_out), .rb_out(rb_out),
    .do_branch(do_branch), .pc_effective(pc_effective));

  always #5 clock = ~clock;

  logic [31:0] imem [32];
  logic [31:0] off;
  always_comb begin
    off    = i_address - 32'h80020000;
    i_insn = (off < 32'd128) ? imem[off[6:2]] : 32'h0;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clr();
    for (int i = 0; i < 32; i++) imem[i] = 32'h0;
  endtask
  task automatic tick();
    @(posedge clock); @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // reset state and fetch sequence; r29/r31 read via ADDU rd,rX,r0
    clr();
    imem[0] = rtype(29, 0, 4, 0, 6'h21);
    imem[1] = rtype(31, 0, 5, 0, 6'h21);
    reset = 1'b1;
    @(negedge clock);
    check("rst_pc", i_address, 32'h80020000);
    check("rst_ir", ir_dx, 32'h0);
    check("rst_rwe", rwe_dx, 0);
    check("rst_br", do_branch, 0);
    check("const_if", {i_mem_enable, i_rw, i_access_size}, 4'b1100);
    reset = 1'b0;
    tick();
    check("pc1", i_address, 32'h80020004);
    check("r29", alu_out, 32'h80120000);
    check("rd_r4", rd_dx, 4);
    check("pcdx0", pc_dx, 32'h80020000);
    tick();
    check("pc2", i_address, 32'h80020008);
    check("r31", alu_out, 32'hDEADBEEF);

    // MX bypass, stall, zero-extended ORI
    clr();
    imem[0] = itype(6'h09, 0, 1, 16'd5);
    imem[1] = rtype(1, 1, 2, 0, 6'h21);
    imem[2] = itype(6'h0d, 0, 3, 16'h8001);
    do_reset();
    tick();
    check("addiu", alu_out, 5);
    check("addiu_rd", rd_dx, 1);
    do_mx_a = 1; do_mx_b = 1; mx_data = 5;
    tick();
    check("bypass_sum", alu_out, 10);
    check("bypass_rd", rd_dx, 2);
    check("bypass_rwe", rwe_dx, 1);
    do_mx_a = 0; do_mx_b = 0; stall = 1;
    tick();
    check("stall_pc", i_address, 32'h80020008);
    check("stall_ir", ir_dx, 0);
    check("stall_we", {rwe_dx, dmwe_dx}, 0);
    check("stall_alu", alu_out, 0);
    stall = 0;
    tick();
    check("unstall_ir", ir_dx, itype(6'h0d, 0, 3, 16'h8001));
    check("unstall_pc", pc_dx, 32'h80020008);
    check("ori_zext", alu_out, 32'h00008001);
    check("unstall_fetch", i_address, 32'h8002000C);

    // taken BEQ with delay slot, then not-taken BNE
    clr();
    imem[0] = itype(6'h04, 0, 0, 16'd3);
    imem[1] = itype(6'h09, 0, 7, 16'd7);
    imem[4] = itype(6'h05, 0, 0, 16'd5);
    do_reset();
    tick();
    check("beq_taken", do_branch, 1);
    check("beq_target", pc_effective, 32'h80020010);
    tick();
    check("br_fetch", i_address, 32'h80020010);
    check("slot_pc", pc_dx, 32'h80020004);
    check("slot_alu", alu_out, 7);
    check("slot_nobr", do_branch, 0);
    tick();
    check("bne_ir", ir_dx, itype(6'h05, 0, 0, 16'd5));
    check("bne_nt", do_branch, 0);

    // JAL, then stall coinciding with the redirect
    clr();
    imem[2] = {6'h03, 26'h0008000};
    do_reset();
    tick(); tick(); tick();
    check("jal_br", do_branch, 1);
    check("jal_target", pc_effective, 32'h80020000);
    check("jal_link", alu_out, 32'h80020010);
    check("jal_rd", rd_dx, 31);
    check("jal_rwe", rwe_dx, 1);
    stall = 1;
    tick();
    check("stbr_pc", i_address, 32'h80020000);
    check("stbr_ir", ir_dx, 0);
    check("stbr_nobr", do_branch, 0);
    stall = 0;

    // writeback: r0 immutable, write-through, then stored value
    clr();
    imem[0] = rtype(0, 0, 9, 0, 6'h21);
    imem[1] = rtype(3, 0, 10, 0, 6'h21);
    imem[2] = rtype(0, 0, 11, 0, 6'h21);
    imem[3] = rtype(3, 0, 12, 0, 6'h21);
    do_reset();
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    tick();
    check("r0_wt", alu_out, 0);
    wb_rd = 3; wb_data = 32'h12345678;
    tick();
    check("r3_wt", alu_out, 32'h12345678);
    wb_we = 0;
    tick();
    check("r0_hold", alu_out, 0);
    tick();
    check("r3_stored", alu_out, 32'h12345678);

    // ALU ops, load/store, unsupported opcode; r3 reinitialised by reset
    clr();
    imem[0] = rtype(0, 31, 13, 4, 6'h03);
    imem[1] = rtype(0, 31, 17, 0, 6'h23);
    imem[2] = itype(6'h0a, 0, 14, 16'hFFFF);
    imem[3] = itype(6'h0b, 0, 15, 16'hFFFF);
    imem[4] = itype(6'h0f, 0, 16, 16'h1234);
    imem[5] = itype(6'h2b, 29, 31, 16'd4);
    imem[6] = itype(6'h23, 29, 18, 16'hFFFC);
    imem[7] = itype(6'h3f, 0, 19, 16'h1111);
    imem[8] = rtype(3, 0, 20, 0, 6'h21);
    do_reset();
    tick(); check("sra", alu_out, 32'hFDEADBEE);
    tick(); check("subu", alu_out, 32'h21524111);
    tick(); check("slti", alu_out, 0);
    tick(); check("sltiu", alu_out, 1);
    tick(); check("lui", alu_out, 32'h12340000);
    tick();
    check("sw_addr", alu_out, 32'h80120004);
    check("sw_data", rb_out, 32'hDEADBEEF);
    check("sw_ctl", {dmwe_dx, rwe_dx}, 2'b10);
    tick();
    check("lw_addr", alu_out, 32'h8011FFFC);
    check("lw_ctl", {rwd_dx, rwe_dx, rd_dx}, {2'b11, 5'd18});
    tick();
    check("bad_alu", alu_out, 0);
    check("bad_we", {rwe_dx, dmwe_dx, rwd_dx}, 0);
    tick();
    check("r3_reinit", alu_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
